// File: rtl/ace_snoop_issue_ctrl.sv
// ace_snoop_issue_ctrl
//   Snoop-master stage in front of the per-line ACE coherence FSM. It takes
//   one snoop request at a time and issues it on the AC channel. It then
//   collects the CR response. When the response announces a data transfer,
//   the CD beats pass straight through to a write-back port. Each snoop ends
//   with a single done pulse that carries the response and an error flag.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/ready     snoop request handshake; req_addr, req_snoop payload
//   acvalid/acready     AC channel to the cache FSM; acaddr, acsnoop payload
//   crvalid/crready     CR response channel; crresp (bit0 DataTransfer, bit1 Error)
//   cdvalid/cdready     CD data channel; cddata, cdlast payload
//   wb_valid/wb_ready   write-back beat port; wb_data, wb_last payload
//   done                one-cycle completion pulse
//   done_resp, done_err captured response and accumulated error, valid with done
module ace_snoop_issue_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int BEATS   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_snoop,
  output logic              acvalid,
  input  logic              acready,
  output logic [ADDR_W-1:0] acaddr,
  output logic              acsnoop,
  input  logic              crvalid,
  output logic              crready,
  input  logic [4:0]        crresp,
  input  logic              cdvalid,
  output logic              cdready,
  input  logic [DATA_W-1:0] cddata,
  input  logic              cdlast,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_last,
  output logic              done,
  output logic [4:0]        done_resp,
  output logic              done_err
);

  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int BCNT_W = $clog2(BEATS + 1);
  localparam logic [TMR_W-1:0]  TMR_MAX   = TMR_W'(TIMEOUT);
  localparam logic [BCNT_W-1:0] BEATS_CNT = BCNT_W'(BEATS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    AC_ISSUE = 3'd1,
    CR_WAIT  = 3'd2,
    CD_XFER  = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t              state;
  logic [TMR_W-1:0]    timer;
  logic [BCNT_W-1:0]   beat;
  logic                err;
  logic [BCNT_W-1:0]   beat_nxt;
  logic                cd_xfer;

  // Timer stops at TIMEOUT instead of wrapping.
  function automatic logic [TMR_W-1:0] tmr_sat_inc(input logic [TMR_W-1:0] t);
    return (t >= TMR_MAX) ? TMR_MAX : t + TMR_W'(1);
  endfunction

  // The CD to write-back path is purely combinational, so it adds no latency.
  // The handshakes are gated by state, so nothing moves outside CD_XFER.
  assign req_ready = (state == IDLE);
  assign wb_valid  = (state == CD_XFER) && cdvalid;
  assign cdready   = (state == CD_XFER) && wb_ready;
  assign wb_data   = cddata;
  assign wb_last   = cdlast;
  assign cd_xfer   = (state == CD_XFER) && cdvalid && wb_ready;
  assign beat_nxt  = beat + BCNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acvalid   <= 1'b0;
      acaddr    <= '0;
      acsnoop   <= 1'b0;
      crready   <= 1'b0;
      done      <= 1'b0;
      done_resp <= '0;
      done_err  <= 1'b0;
      timer     <= '0;
      beat      <= '0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            acaddr  <= req_addr;
            acsnoop <= req_snoop;
            acvalid <= 1'b1;
            state   <= AC_ISSUE;
          end
        end

        // AC valid is never withdrawn once raised, so this state has no timeout.
        AC_ISSUE: begin
          if (acready) begin
            acvalid <= 1'b0;
            crready <= 1'b1;
            timer   <= '0;
            state   <= CR_WAIT;
          end
        end

        // A response that arrives on the timeout cycle still wins.
        CR_WAIT: begin
          if (crvalid) begin
            done_resp <= crresp;
            crready   <= 1'b0;
            err       <= crresp[1];
            if (crresp[0]) begin
              beat  <= '0;
              timer <= '0;
              state <= CD_XFER;
            end else begin
              done     <= 1'b1;
              done_err <= crresp[1];
              state    <= DONE;
            end
          end else if (timer >= TMR_MAX) begin
            done_resp <= '0;
            err       <= 1'b1;
            crready   <= 1'b0;
            done      <= 1'b1;
            done_err  <= 1'b1;
            state     <= DONE;
          end else begin
            timer <= tmr_sat_inc(timer);
          end
        end

        // The burst ends on cdlast or on the BEATS-th beat, whichever comes first.
        // It is clean only when both coincide and the response carried no error.
        CD_XFER: begin
          if (cd_xfer) begin
            beat  <= beat_nxt;
            timer <= '0;
            if (cdlast || (beat_nxt == BEATS_CNT)) begin
              done     <= 1'b1;
              done_err <= err | (beat_nxt != BEATS_CNT) | ~cdlast;
              state    <= DONE;
            end
          end else if (timer >= TMR_MAX) begin
            err      <= 1'b1;
            done     <= 1'b1;
            done_err <= 1'b1;
            state    <= DONE;
          end else begin
            timer <= tmr_sat_inc(timer);
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ace_snoop_issue_ctrl.sv
module tb_ace_snoop_issue_ctrl;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int BEATS   = 4;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_snoop;
  logic              acvalid;
  logic              acready;
  logic [ADDR_W-1:0] acaddr;
  logic              acsnoop;
  logic              crvalid;
  logic              crready;
  logic [4:0]        crresp;
  logic              cdvalid;
  logic              cdready;
  logic [DATA_W-1:0] cddata;
  logic              cdlast;
  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_data;
  logic              wb_last;
  logic              done;
  logic [4:0]        done_resp;
  logic              done_err;

  ace_snoop_issue_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_snoop(req_snoop),
    .acvalid(acvalid), .acready(acready), .acaddr(acaddr), .acsnoop(acsnoop),
    .crvalid(crvalid), .crready(crready), .crresp(crresp),
    .cdvalid(cdvalid), .cdready(cdready), .cddata(cddata), .cdlast(cdlast),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_last(wb_last),
    .done(done), .done_resp(done_resp), .done_err(done_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        snoop;
    logic [31:0] addr;
    int          ac_dly;
    int          cr_dly;
    logic [4:0]  resp;
    int          nbeats;
    int          last_at;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic tog;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a request and run the AC handshake. Returns in the first CR_WAIT cycle.
  task automatic issue(input logic snoop, input logic [31:0] addr, input int ac_dly);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_addr = addr; req_snoop = snoop;
    step();
    req_valid = 1'b0; req_addr = '0; req_snoop = 1'b0;
    for (int d = 0; d < ac_dly; d++) begin
      chk("acvalid_hold", acvalid, 1'b1);
      chk("acaddr_hold", acaddr, addr);
      chk("acsnoop_hold", acsnoop, snoop);
      step();
    end
    acready = 1'b1;
    #1;
    chk("acvalid_hs", acvalid, 1'b1);
    chk("acaddr_hs", acaddr, addr);
    step();
    acready = 1'b0;
    chk("acvalid_low", acvalid, 1'b0);
    chk("crready_cr", crready, 1'b1);
  endtask

  // Run one complete snoop from a vector. On return the DUT is in IDLE.
  task automatic do_snoop(input vec_t v);
    bit got;
    issue(v.snoop, v.addr, v.ac_dly);
    for (int d = 0; d < v.cr_dly; d++) begin
      chk({v.name, "_crready"}, crready, 1'b1);
      step();
    end
    crvalid = 1'b1; crresp = v.resp;
    step();
    crvalid = 1'b0; crresp = '0;
    chk({v.name, "_crready_off"}, crready, 1'b0);
    tog = 1'b1;
    for (int i = 0; i < v.nbeats; i++) begin
      cdvalid = 1'b1; cddata = 64'hA0 + 64'(i); cdlast = (i == v.last_at);
      got = 1'b0;
      for (int w = 0; w < 6 && !got; w++) begin
        wb_ready = tog; tog = ~tog;
        #1;
        chk({v.name, "_wb_valid"}, wb_valid, 1'b1);
        if (wb_ready) begin
          chk({v.name, "_wb_data"}, wb_data, 64'hA0 + 64'(i));
          chk({v.name, "_wb_last"}, wb_last, (i == v.last_at));
          chk({v.name, "_cdready"}, cdready, 1'b1);
          got = 1'b1;
        end else begin
          chk({v.name, "_cdready_stall"}, cdready, 1'b0);
        end
        step();
      end
      if (!got) chk({v.name, "_beat_accept"}, 1'b0, 1'b1);
    end
    cdvalid = 1'b0; cdlast = 1'b0; wb_ready = 1'b0;
    chk({v.name, "_done"}, done, 1'b1);
    chk({v.name, "_done_resp"}, done_resp, v.resp);
    chk({v.name, "_done_err"}, done_err, v.exp_err);
    // Offer a stray beat during DONE: it must not be accepted.
    cdvalid = 1'b1; wb_ready = 1'b1;
    #1;
    chk({v.name, "_cdready_after"}, cdready, 1'b0);
    chk({v.name, "_wb_valid_after"}, wb_valid, 1'b0);
    step();
    cdvalid = 1'b0; wb_ready = 1'b0;
    chk({v.name, "_done_pulse"}, done, 1'b0);
    chk({v.name, "_idle"}, req_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          name        snoop addr        ac cr resp   nb last err
    vecs[0] = '{"clean",    1'b1, 32'h1000,   2, 1, 5'h00, 0, 0,  1'b0};
    vecs[1] = '{"data",     1'b0, 32'h2040,   0, 0, 5'h01, 4, 3,  1'b0};
    vecs[2] = '{"short",    1'b0, 32'h3000,   1, 2, 5'h01, 2, 1,  1'b1};
    vecs[3] = '{"nolast",   1'b1, 32'h4000,   0, 0, 5'h01, 4, 99, 1'b1};
    vecs[4] = '{"errresp",  1'b0, 32'h5000,   1, 0, 5'h02, 0, 0,  1'b1};
    vecs[5] = '{"dataerr",  1'b1, 32'h6080,   0, 3, 5'h03, 4, 3,  1'b1};

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_snoop = 1'b0;
    acready = 1'b0; crvalid = 1'b0; crresp = '0;
    cdvalid = 1'b0; cddata = '0; cdlast = 1'b0; wb_ready = 1'b0;
    step(); step();
    chk("rst_acvalid", acvalid, 1'b0);
    chk("rst_acaddr", acaddr, 32'h0);
    chk("rst_acsnoop", acsnoop, 1'b0);
    chk("rst_crready", crready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_done_resp", done_resp, 5'h0);
    chk("rst_done_err", done_err, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_cdready", cdready, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    rst_n = 1'b1;
    step();

    for (int k = 0; k < 6; k++) do_snoop(vecs[k]);

    // CR timeout: entry cycle is cycle 0, done must appear in cycle 9.
    issue(1'b0, 32'h7000, 0);
    for (int c = 0; c <= TIMEOUT; c++) begin
      chk("to_wait_done", done, 1'b0);
      chk("to_wait_crready", crready, 1'b1);
      step();
    end
    chk("to_done", done, 1'b1);
    chk("to_done_err", done_err, 1'b1);
    chk("to_done_resp", done_resp, 5'h0);
    step();
    chk("to_idle", req_ready, 1'b1);

    // Response on the timeout cycle completes normally.
    issue(1'b1, 32'h7100, 1);
    for (int c = 0; c < TIMEOUT; c++) step();
    chk("to_edge_crready", crready, 1'b1);
    crvalid = 1'b1; crresp = 5'h10;
    step();
    crvalid = 1'b0; crresp = '0;
    chk("to_edge_done", done, 1'b1);
    chk("to_edge_err", done_err, 1'b0);
    chk("to_edge_resp", done_resp, 5'h10);
    step();

    // Reset in the middle of a CD burst, after two beats.
    issue(1'b0, 32'h8000, 0);
    crvalid = 1'b1; crresp = 5'h01;
    step();
    crvalid = 1'b0; crresp = '0;
    wb_ready = 1'b1; cdvalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cddata = 64'hB0 + 64'(i);
      #1;
      chk("mid_wb_data", wb_data, 64'hB0 + 64'(i));
      step();
    end
    cddata = 64'hB2;
    #1;
    chk("mid_wb_valid_pre", wb_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_acvalid", acvalid, 1'b0);
    chk("mid_rst_crready", crready, 1'b0);
    chk("mid_rst_cdready", cdready, 1'b0);
    chk("mid_rst_wb_valid", wb_valid, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_idle", req_ready, 1'b1);
    #1;
    rst_n = 1'b1;
    cdvalid = 1'b0; wb_ready = 1'b0; cddata = '0;
    step();
    chk("mid_no_done", done, 1'b0);
    do_snoop(vecs[1]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
